capture_buffer: RTL and testbench

CAPTURE_BUFFER -- requirements
Module: capture_buffer

---
 rtl/capture_pkg.sv | 20 ++
 rtl/capture_ram.sv | 32 +++
 rtl/capture_buffer.sv | 205 ++++++++++++++++++++
 tb/tb_capture_buffer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared types and helpers for the pre/post-trigger capture buffer.
package capture_pkg;

    // Capture sequencing states.
    typedef enum logic [2:0] {
        ST_PRE_FILL   = 3'd0,
        ST_ARMED      = 3'd1,
        ST_CAPTURE    = 3'd2,
        ST_READOUT    = 3'd3,
        ST_WAIT_CLEAR = 3'd4
    } state_t;

    localparam int SAMPLE_W = 16;

    // Address width for a buffer of the given depth.
    function automatic int addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample store: synchronous write, registered read (1-cycle latency).
import capture_pkg::*;

module capture_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic                pcm_clk,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [SAMPLE_W-1:0] wr_data,
    input  logic                rd_en,
    input  logic [AW-1:0]       rd_addr,
    output logic [SAMPLE_W-1:0] rd_data
);

    logic [SAMPLE_W-1:0] mem [DEPTH];
    logic [SAMPLE_W-1:0] rd_q;

    // Write port.
    always_ff @(posedge pcm_clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Registered read port; contents and read register are intentionally not reset.
    always_ff @(posedge pcm_clk) begin
        if (rd_en) rd_q <= mem[rd_addr];
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/capture_buffer.sv
// Pre/post-trigger capture buffer with a zero-bubble valid/ready readout.
//
// state         | meaning
// --------------+-------------------------------------------------------------
// ST_PRE_FILL   | writing the first PRE_TRIGGER samples, trigger ignored
// ST_ARMED      | writing continuously, waiting for the trigger level
// ST_CAPTURE    | writing the post-trigger samples, trigger ignored
// ST_READOUT    | streaming DEPTH samples oldest-first through out/skid regs
// ST_WAIT_CLEAR | capture delivered, waiting for the trigger level to drop
import capture_pkg::*;

module capture_buffer #(
    parameter int DEPTH       = 256,
    parameter int PRE_TRIGGER = 64
) (
    input  logic                       pcm_clk,
    input  logic                       reset,
    input  logic signed [SAMPLE_W-1:0] pcm,
    input  logic                       triggered,
    input  logic                       rd_ready,
    output logic signed [SAMPLE_W-1:0] rd_data,
    output logic                       rd_valid,
    output logic                       armed,
    output logic                       capturing,
    output logic                       done
);

    localparam int AW = addr_w(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] FILL_LAST = AW'(PRE_TRIGGER - 1);
    localparam logic [AW-1:0] CAP_LAST  = AW'(DEPTH - PRE_TRIGGER - 1);
    localparam bit            CAP_ONE   = (DEPTH - PRE_TRIGGER) == 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);

    state_t              state_q, state_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [AW-1:0]       rd_addr_q, rd_addr_d;
    logic [CW-1:0]       issue_left_q, issue_left_d;
    logic [CW-1:0]       pop_left_q, pop_left_d;
    logic                ram_vld_q, ram_vld_d;
    logic [SAMPLE_W-1:0] rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic [SAMPLE_W-1:0] skid_data_q, skid_data_d;
    logic                skid_valid_q, skid_valid_d;
    logic                armed_q, armed_d;
    logic                capturing_q, capturing_d;
    logic                done_q, done_d;

    logic                wr_en, rd_en, pop;
    logic [1:0]          occ;
    logic [SAMPLE_W-1:0] ram_dout;

    capture_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .pcm_clk (pcm_clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (pcm),
        .rd_en   (rd_en),
        .rd_addr (rd_addr_q),
        .rd_data (ram_dout)
    );

    // Next-state, pointer, counter and readout-pipeline logic.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        cnt_d        = cnt_q;
        rd_addr_d    = rd_addr_q;
        issue_left_d = issue_left_q;
        pop_left_d   = pop_left_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = rd_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        pop          = rd_valid_q & rd_ready;
        // Samples held or in flight once this cycle's transfer (if any) is taken.
        occ          = {1'b0, rd_valid_q} + {1'b0, skid_valid_q} + {1'b0, ram_vld_q} - {1'b0, pop};

        case (state_q)
            ST_PRE_FILL: begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (cnt_q == FILL_LAST) begin
                    state_d = ST_ARMED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ARMED: begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (triggered) begin
                    if (CAP_ONE) begin
                        state_d      = ST_READOUT;
                        rd_addr_d    = wr_ptr_d;
                        issue_left_d = DEPTH_C;
                        pop_left_d   = DEPTH_C;
                    end else begin
                        state_d = ST_CAPTURE;
                        cnt_d   = AW'(1);
                    end
                end
            end
            ST_CAPTURE: begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (cnt_q == CAP_LAST) begin
                    // wr_ptr now points at the oldest sample in the buffer.
                    state_d      = ST_READOUT;
                    cnt_d        = '0;
                    rd_addr_d    = wr_ptr_d;
                    issue_left_d = DEPTH_C;
                    pop_left_d   = DEPTH_C;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READOUT: begin
                // Only prefetch when the returning word is guaranteed a slot.
                if (issue_left_q != '0 && occ < 2'd2) begin
                    rd_en        = 1'b1;
                    rd_addr_d    = rd_addr_q + 1'b1;
                    issue_left_d = issue_left_q - 1'b1;
                end
                if (pop && pop_left_q == CW'(1)) state_d = ST_WAIT_CLEAR;
            end
            ST_WAIT_CLEAR: begin
                if (!triggered) begin
                    state_d = ST_PRE_FILL;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_PRE_FILL;
        endcase

        ram_vld_d = rd_en;

        // Output register holds while stalled; RAM data lands in the skid register.
        if (rd_valid_q && !pop) begin
            if (ram_vld_q) begin
                skid_data_d  = ram_dout;
                skid_valid_d = 1'b1;
            end
        end else if (skid_valid_q) begin
            rd_data_d    = skid_data_q;
            rd_valid_d   = 1'b1;
            skid_data_d  = ram_dout;
            skid_valid_d = ram_vld_q;
        end else begin
            if (ram_vld_q) rd_data_d = ram_dout;
            rd_valid_d = ram_vld_q;
        end
        if (pop) pop_left_d = pop_left_q - 1'b1;

        armed_d     = (state_d == ST_ARMED);
        capturing_d = (state_d == ST_CAPTURE);
        done_d      = (state_d == ST_READOUT) || (state_d == ST_WAIT_CLEAR);
    end

    // State, pointers and registered outputs; reset abandons any capture in progress.
    always_ff @(posedge pcm_clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_PRE_FILL;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            rd_addr_q    <= '0;
            issue_left_q <= '0;
            pop_left_q   <= '0;
            ram_vld_q    <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
            armed_q      <= 1'b0;
            capturing_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            rd_addr_q    <= rd_addr_d;
            issue_left_q <= issue_left_d;
            pop_left_q   <= pop_left_d;
            ram_vld_q    <= ram_vld_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
            armed_q      <= armed_d;
            capturing_q  <= capturing_d;
            done_q       <= done_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign armed     = armed_q;
    assign capturing = capturing_q;
    assign done      = done_q;

endmodule

// File: tb/tb_capture_buffer.sv
// Randomized bench for capture_buffer (DEPTH=16, PRE_TRIGGER=4) with a window reference model.
module tb_capture_buffer;

    localparam int DEPTH = 16;
    localparam int PRE   = 4;
    localparam int CAP   = DEPTH - PRE;

    logic        pcm_clk   = 1'b0;
    logic        reset     = 1'b1;
    logic [15:0] pcm       = '0;
    logic        triggered = 1'b0;
    logic        rd_ready  = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid, armed, capturing, done;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] vals [256];

    capture_buffer #(.DEPTH(DEPTH), .PRE_TRIGGER(PRE)) dut (
        .pcm_clk   (pcm_clk),
        .reset     (reset),
        .pcm       (pcm),
        .triggered (triggered),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .armed     (armed),
        .capturing (capturing),
        .done      (done)
    );

    always #5 pcm_clk = ~pcm_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_valid"}, rd_valid, 0);
        check_val({tag, "_data"}, rd_data, 0);
        check_val({tag, "_armed"}, armed, 0);
        check_val({tag, "_capturing"}, capturing, 0);
        check_val({tag, "_done"}, done, 0);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        rd_ready  = 1'b0;
        triggered = 1'b0;
        pcm       = '0;
        #1;
        check_idle("reset");
        repeat (2) @(posedge pcm_clk);
        #1 reset = 1'b0;
    endtask

    // One capture starting from the first PRE_FILL cycle. Model: the trigger lands on the
    // first sample index >= PRE with triggered high, and the readout is the DEPTH-sample
    // window starting PRE samples before it.
    task automatic run_capture(input int trig_k, input int mode, input bit rnd,
                               input int hold, input int abort_n);
        int t, k_entry, received, first_k, k;
        bit prev_stall, rdy;
        logic [15:0] prev_data;
        for (int i = 0; i < 256; i++) vals[i] = rnd ? 16'($urandom) : 16'(i + 1);
        t          = (trig_k > PRE) ? trig_k : PRE;
        k_entry    = t + CAP;
        received   = 0;
        first_k    = -1;
        k          = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        while (1) begin
            @(negedge pcm_clk);
            check_val("armed", armed, (k >= PRE && k <= t));
            check_val("capturing", capturing, (k > t && k < k_entry));
            check_val("done", done, (k >= k_entry));
            if (k < k_entry) check_val("early_valid", rd_valid, 0);
            if (prev_stall) begin
                check_val("hold_valid", rd_valid, 1);
                check_val("hold_data", rd_data, prev_data);
            end
            if (rd_valid && first_k < 0) first_k = k;
            if (mode == 0 && first_k >= 0 && received < DEPTH) check_val("bubble", rd_valid, 1);
            pcm       = (k < 256) ? vals[k] : 16'h0;
            triggered = (k >= trig_k);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (k % 4 == 0) || (k % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            rd_ready = rdy;
            if (rd_valid && rdy) begin
                check_val("data", rd_data, vals[t - PRE + received]);
                received++;
            end
            prev_stall = rd_valid && !rdy;
            prev_data  = rd_data;
            k++;
            if (received == DEPTH || (abort_n > 0 && received == abort_n)) break;
            if (k >= 400) begin
                check_val("timeout", received, DEPTH);
                break;
            end
        end
        check_val("first_latency", (first_k >= k_entry && first_k <= k_entry + 2), 1);
        if (abort_n > 0) return;
        repeat (hold) begin
            @(negedge pcm_clk);
            check_val("wc_valid", rd_valid, 0);
            check_val("wc_done", done, 1);
            check_val("wc_armed", armed, 0);
            check_val("wc_capturing", capturing, 0);
            triggered = 1'b1;
        end
        triggered = 1'b0;
    endtask

    initial begin
        do_reset();
        run_capture(9, 0, 1'b0, 20, 0);   // trigger at pcm=10 -> 6..21, long WAIT_CLEAR hold
        do_reset();
        run_capture(0, 0, 1'b0, 3, 0);    // trigger high from start -> 1..16
        do_reset();
        run_capture(9, 1, 1'b0, 3, 0);    // 1,0,0,1 ready pattern
        do_reset();
        run_capture(39, 0, 1'b0, 3, 0);   // trigger at pcm=40 -> 36..51 across wrap

        do_reset();
        run_capture(9, 0, 1'b0, 1, 7);    // abandon after 7th transfer
        @(posedge pcm_clk);
        #1 reset = 1'b1;
        #1 check_idle("midreset");
        repeat (2) @(posedge pcm_clk);
        #1 reset = 1'b0;
        triggered = 1'b0;
        run_capture(7, 0, 1'b0, 3, 0);    // trigger at pcm=8 -> 4..19

        for (int i = 0; i < 6; i++) begin
            run_capture(int'($urandom_range(0, 40)), int'($urandom_range(0, 2)), 1'b1,
                        int'($urandom_range(1, 5)), 0);
        end
        @(negedge pcm_clk);
        check_val("final_done", done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
